// File: rtl/acc_seq_ctrl_if.sv
// Tree-beat, accumulator-control and result-port bundle around acc_seq_ctrl.
// master = the controller, slave = tree/accumulator/downstream side.
interface acc_seq_ctrl_if #(
  parameter int ACC_W = 32
);
  logic             tree_valid_i;
  logic             tree_ready_o;
  logic             acc_en_o;
  logic             acc_sel_o;
  logic [ACC_W-1:0] acc_data_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [ACC_W-1:0] res_data_o;

  modport master (
    input  tree_valid_i, acc_data_i, res_ready_i,
    output tree_ready_o, acc_en_o, acc_sel_o, res_valid_o, res_data_o
  );

  modport slave (
    output tree_valid_i, acc_data_i, res_ready_i,
    input  tree_ready_o, acc_en_o, acc_sel_o, res_valid_o, res_data_o
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Sequencing controller for the tile accumulator: counts N tree beats per job,
// steers the accumulator clear/add select and presents the sum on a valid/ready port.
module acc_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_tiles_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             err_o,
  output logic             done_o,
  acc_seq_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic [CNT_W-1:0] numTiles_q, numTiles_d;
  logic [CNT_W-1:0] lastBeat;

  // Index of the final beat; a latched count of zero never reaches ACCUM.
  assign lastBeat = numTiles_q - CNT_W'(1);
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beatCnt_q  <= '0;
      numTiles_q <= '0;
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      numTiles_q <= numTiles_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    beatCnt_d        = beatCnt_q;
    numTiles_d       = numTiles_q;
    bus.tree_ready_o = 1'b0;
    bus.acc_en_o     = 1'b0;
    bus.acc_sel_o    = 1'b0;
    bus.res_valid_o  = 1'b0;
    bus.res_data_o   = '0;
    err_o            = 1'b0;
    done_o           = 1'b0;

    // Abort wins over every other event and silences all strobes this cycle.
    if (abort_i) begin
      state_d   = IDLE;
      beatCnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_tiles_i == '0) begin
              err_o = 1'b1;
            end else begin
              numTiles_d = num_tiles_i;
              beatCnt_d  = '0;
              state_d    = ACCUM;
            end
          end
        end

        ACCUM: begin
          bus.tree_ready_o = 1'b1;
          bus.acc_sel_o    = (beatCnt_q != '0);
          if (bus.tree_valid_i) begin
            bus.acc_en_o = 1'b1;
            beatCnt_d    = beatCnt_q + CNT_W'(1);
            if (beatCnt_q == lastBeat) begin
              state_d = DONE;
            end
          end
        end

        DONE: begin
          bus.res_valid_o = 1'b1;
          bus.res_data_o  = bus.acc_data_i;
          // A start on the handshake cycle chains the next job without an idle gap.
          if (bus.res_ready_i) begin
            done_o  = 1'b1;
            state_d = IDLE;
            if (start_i) begin
              if (num_tiles_i == '0) begin
                err_o = 1'b1;
              end else begin
                numTiles_d = num_tiles_i;
                beatCnt_d  = '0;
                state_d    = ACCUM;
              end
            end
          end
        end

        default: begin
          state_d   = IDLE;
          beatCnt_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: job-level reference model (beat queue and
// running sum) compared every cycle, plus literal expectations for the directed jobs.
module tb_acc_seq_ctrl;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] num_tiles_i = '0;
  logic             abort_i = 1'b0;
  logic             busy_o, err_o, done_o;
  logic [ACC_W-1:0] treeData = '0;
  logic [ACC_W-1:0] accReg;

  acc_seq_ctrl_if #(.ACC_W(ACC_W)) bus ();

  acc_seq_ctrl #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .num_tiles_i (num_tiles_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .done_o      (done_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the external accumulator register the controller steers.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) accReg <= '0;
    else if (bus.acc_en_o) accReg <= bus.acc_sel_o ? accReg + treeData : treeData;
  end
  assign bus.acc_data_i = accReg;

  int testsRun = 0;
  int testsFailed = 0;

  // Job-level model: 0 = no job, 1 = collecting beats, 2 = result pending.
  int               mPhase = 0;
  int unsigned      mTiles = 0;
  logic [ACC_W-1:0] beatQ[$];
  logic [ACC_W-1:0] mSum = '0;

  logic [ACC_W-1:0] lastDutRes = '0;
  logic [ACC_W-1:0] lastModelRes = '0;
  logic [31:0]      selBits = '0;
  int errCnt = 0, doneCnt = 0, accEnCnt = 0, busyCnt = 0, resValidCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [CNT_W-1:0] nt, input logic ab,
                               input logic tv, input logic [ACC_W-1:0] td, input logic rr);
    start_i          = st;
    num_tiles_i      = nt;
    abort_i          = ab;
    bus.tree_valid_i = tv;
    treeData         = td;
    bus.res_ready_i  = rr;
  endtask

  task automatic modelReset();
    mPhase = 0;
    beatQ.delete();
  endtask

  // Compares all outputs against the model for the current inputs, then advances the model.
  task automatic checkOutput();
    logic collecting, eResValid;
    logic [ACC_W-1:0] s;
    collecting = (mPhase == 1) && !abort_i;
    eResValid  = (mPhase == 2) && !abort_i;
    check("tree_ready", 32'(bus.tree_ready_o), 32'(collecting));
    check("acc_en",     32'(bus.acc_en_o),     32'(collecting && bus.tree_valid_i));
    check("acc_sel",    32'(bus.acc_sel_o),    32'(collecting && beatQ.size() != 0));
    check("res_valid",  32'(bus.res_valid_o),  32'(eResValid));
    check("res_data",   bus.res_data_o,        eResValid ? mSum : '0);
    check("busy",       32'(busy_o),           32'(mPhase != 0));
    check("done",       32'(done_o),           32'(eResValid && bus.res_ready_i));
    check("err",        32'(err_o),            32'(!abort_i && start_i && num_tiles_i == '0 &&
                                                   (mPhase == 0 || (mPhase == 2 && bus.res_ready_i))));
    if (err_o) errCnt++;
    if (done_o) doneCnt++;
    if (busy_o) busyCnt++;
    if (bus.res_valid_o) begin
      resValidCnt++;
      lastDutRes = bus.res_data_o;
    end
    if (bus.acc_en_o) begin
      accEnCnt++;
      selBits = {selBits[30:0], bus.acc_sel_o};
    end
    if (eResValid) lastModelRes = mSum;

    if (abort_i) begin
      modelReset();
    end else if (mPhase == 0 || (mPhase == 2 && bus.res_ready_i)) begin
      mPhase = 0;
      if (start_i && num_tiles_i != '0) begin
        mPhase = 1;
        mTiles = int'(num_tiles_i);
        beatQ.delete();
      end
    end else if (mPhase == 1 && bus.tree_valid_i) begin
      beatQ.push_back(treeData);
      if (beatQ.size() == mTiles) begin
        s = '0;
        foreach (beatQ[i]) s = s + beatQ[i];
        mSum   = s;
        mPhase = 2;
      end
    end
  endtask

  task automatic runCycle(input logic st, input logic [CNT_W-1:0] nt, input logic ab,
                          input logic tv, input logic [ACC_W-1:0] td, input logic rr);
    applyStimulus(st, nt, ab, tv, td, rr);
    #4;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int base, baseErr, baseBusy, baseDone, baseRv;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    check("reset_busy",      32'(busy_o), 32'h0);
    check("reset_res_valid", 32'(bus.res_valid_o), 32'h0);
    check("reset_tree_rdy",  32'(bus.tree_ready_o), 32'h0);
    check("reset_acc_en",    32'(bus.acc_en_o), 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idleCycle();

    // Basic job: +5, -2, +7.
    $display("[TB] basic job");
    base = accEnCnt; baseDone = doneCnt; selBits = '0;
    runCycle(1'b1, CNT_W'(3), 1'b0, 1'b0, '0, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd5, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd7, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("basic_sel_seq",   32'(selBits[2:0]), 32'h3);
    check("basic_en_count",  32'(accEnCnt - base), 32'd3);
    check("basic_res",       lastDutRes, 32'h0000_000A);
    check("basic_model_res", lastModelRes, 32'h0000_000A);
    check("basic_done",      32'(doneCnt - baseDone), 32'd1);
    idleCycle();

    // Bubbles between beats, then five stall cycles on the result port.
    $display("[TB] bubbles and backpressure");
    base = accEnCnt;
    runCycle(1'b1, CNT_W'(4), 1'b0, 1'b0, '0, 1'b0);
    for (int b = 1; b <= 4; b++) begin
      runCycle(1'b0, '0, 1'b0, 1'b1, ACC_W'(b), 1'b0);
      if (b != 4) begin
        runCycle(1'b0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        runCycle(1'b0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      end
    end
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      #4;
      checkOutput();
      check("stall_res_data", bus.res_data_o, 32'h0000_000A);
      check("stall_done",     32'(done_o), 32'h0);
      @(posedge clk);
      #1;
    end
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("bubble_en_count", 32'(accEnCnt - base), 32'd4);

    // Back-to-back: B starts on A's handshake and must clear the stale sum.
    $display("[TB] back-to-back");
    runCycle(1'b1, CNT_W'(2), 1'b0, 1'b0, '0, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_7FFF, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_7FFF, 1'b0);
    runCycle(1'b1, CNT_W'(1), 1'b0, 1'b0, '0, 1'b1);
    check("b2b_a_res", lastDutRes, 32'h0000_FFFE);
    selBits = '1;
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    check("b2b_b_sel", 32'(selBits[0]), 32'h0);
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("b2b_b_res", lastDutRes, 32'hFFFF_FFFF);

    // Zero count.
    $display("[TB] zero count");
    base = accEnCnt; baseErr = errCnt; baseBusy = busyCnt;
    runCycle(1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    idleCycle();
    idleCycle();
    check("zero_err",   32'(errCnt - baseErr), 32'd1);
    check("zero_busy",  32'(busyCnt - baseBusy), 32'd0);
    check("zero_acc_en", 32'(accEnCnt - base), 32'd0);

    // Abort after two beats, then a fresh single-beat job.
    $display("[TB] abort");
    baseDone = doneCnt; baseRv = resValidCnt;
    runCycle(1'b1, CNT_W'(5), 1'b0, 1'b0, '0, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd11, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd12, 1'b0);
    runCycle(1'b0, '0, 1'b1, 1'b1, 32'd13, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
    #4;
    checkOutput();
    check("abort_idle_busy", 32'(busy_o), 32'h0);
    @(posedge clk);
    #1;
    check("abort_no_valid", 32'(resValidCnt - baseRv), 32'd0);
    check("abort_no_done",  32'(doneCnt - baseDone), 32'd0);
    runCycle(1'b1, CNT_W'(1), 1'b0, 1'b0, '0, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd9, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("after_abort_res", lastDutRes, 32'h0000_0009);

    // Asynchronous reset while the result is waiting.
    $display("[TB] reset mid-job");
    baseDone = doneCnt;
    runCycle(1'b1, CNT_W'(1), 1'b0, 1'b0, '0, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'h55, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    check("pre_reset_valid", 32'(bus.res_valid_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("async_res_valid", 32'(bus.res_valid_o), 32'h0);
    check("async_busy",      32'(busy_o), 32'h0);
    check("async_tree_rdy",  32'(bus.tree_ready_o), 32'h0);
    check("async_no_done",   32'(done_o), 32'h0);
    modelReset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    runCycle(1'b1, CNT_W'(2), 1'b0, 1'b0, '0, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd4, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b1, 32'd6, 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("post_reset_res",  lastDutRes, 32'h0000_000A);
    check("post_reset_done", 32'(doneCnt - baseDone), 32'd1);

    // Long job exercising the upper counter bits.
    $display("[TB] long job");
    runCycle(1'b1, CNT_W'(300), 1'b0, 1'b0, '0, 1'b0);
    for (int b = 0; b < 300; b++) runCycle(1'b0, '0, 1'b0, 1'b1, ACC_W'($urandom), 1'b0);
    runCycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("long_res", lastDutRes, lastModelRes);

    // Randomized traffic.
    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      runCycle($urandom_range(0, 99) < 30,
               CNT_W'($urandom_range(0, 6)),
               $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 70,
               ACC_W'($urandom),
               $urandom_range(0, 99) < 60);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
